// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   ps2_state_e         - frame-assembly FSM states
//   PS2_FILTER_LEN      - default clock glitch-filter length (samples)
//   PS2_TIMEOUT_CYCLES  - default partial-frame timeout (cpuclk cycles)
//   odd_parity_ok()     - 1 when data bits plus parity bit hold an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam int PS2_FILTER_LEN     = 8;
  localparam int PS2_TIMEOUT_CYCLES = 25000;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: first-word fall-through FIFO for received scancodes.
//   clk, reset     - clock, synchronous active-high reset
//   push/push_data - write request and byte
//   pop            - read request, honoured only while valid
//   rd_data/valid  - head entry and non-empty flag
//   overflow       - one-cycle pulse when a push is dropped because the FIFO is full
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok = push && (!full || pop_ok);

  assign rd_data = mem[rd_ptr];
  assign valid   = !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else begin
      overflow <= push && full && !pop_ok;
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver (device-to-host frames).
//   clk, reset             - cpuclk, synchronous active-high reset
//   ps2_clk_in/data_in     - raw asynchronous PS/2 lines
//   code/code_valid        - scancode at FIFO head, FIFO non-empty
//   code_ready             - consumer pop (taken when code_valid && code_ready)
//   parity_err, frame_err  - one-cycle pulses for bad parity, bad stop bit or timeout
//   overflow               - one-cycle pulse when a good byte is dropped on a full FIFO
module ps2_kbd_rx import ps2_pkg::*; #(
  parameter int FILTER_LEN     = PS2_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic [7:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  // Input synchronizers, idle-high.
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_s;
  logic       data_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Glitch filter: the counter tracks how many consecutive samples disagree with
  // the filtered level; any agreeing sample restarts the run.
  logic          filt_clk;
  logic          filt_clk_q;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_clk   <= 1'b1;
      filt_clk_q <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      filt_clk_q <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = filt_clk_q && !filt_clk;

  // Frame assembly FSM.
  ps2_state_e    state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          parity_ok, parity_ok_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          push;
  logic          perr_n;
  logic          ferr_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_ok  <= 1'b0;
      to_cnt     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      parity_ok  <= parity_ok_n;
      to_cnt     <= to_cnt_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    parity_ok_n = parity_ok;
    push        = 1'b0;
    perr_n      = 1'b0;
    ferr_n      = 1'b0;

    if (state == ST_IDLE || fall) begin
      to_cnt_n = '0;
    end else begin
      to_cnt_n = to_cnt + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (fall && !data_s) begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_n   = {data_s, shift[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            state_n = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (fall) begin
          parity_ok_n = odd_parity_ok(shift, data_s);
          state_n     = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          if (!parity_ok) begin
            perr_n = 1'b1;
          end else if (!data_s) begin
            ferr_n = 1'b1;
          end else begin
            push = 1'b1;
          end
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A fall on the expiry cycle restarts the count, so it takes precedence.
    if (state != ST_IDLE && !fall && to_cnt == TO_LAST) begin
      state_n  = ST_IDLE;
      ferr_n   = 1'b1;
      to_cnt_n = '0;
    end
  end

  ps2_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift),
    .pop       (code_ready),
    .rd_data   (code),
    .valid     (code_valid),
    .overflow  (overflow)
  );

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, 8: consecutive equal samples needed to change the filtered PS/2 clock level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 25000: idle cycles after which a partial frame is abandoned (500 us at 50 MHz).
REQ-003 SHALL have parameter FIFO_DEPTH, 4: received-byte buffer depth, power of two.
REQ-004 SHALL have port clk, input, 1: sole clock (cpuclk domain).
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ps2_clk_in, input, 1: raw asynchronous keyboard PS/2 clock.
REQ-007 SHALL have port ps2_data_in, input, 1: raw asynchronous keyboard PS/2 data.
REQ-008 SHALL have port code, output, 8: scancode at FIFO head.
REQ-009 SHALL have port code_valid, output, 1: FIFO non-empty.
REQ-010 SHALL have port code_ready, input, 1: consumer pop; pop occurs on a cycle with code_valid && code_ready.
REQ-011 SHALL have ports parity_err, frame_err, overflow, each output, 1: one-cycle error pulses.

Function
REQ-012 SHALL pass both inputs through a 2-flop synchronizer before any use.
REQ-013 SHALL drive the filtered clock to 0 after FILTER_LEN consecutive synchronized 0 samples, to 1 after FILTER_LEN consecutive 1 samples, otherwise hold it.
REQ-014 SHALL generate a one-cycle fall strobe when the filtered clock goes 1->0, and sample synchronized data on that cycle.
REQ-015 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: fall with data=0 -> DATA with bit count 0; fall with data=1 -> stay IDLE, no error.
REQ-017 DATA: each fall shifts data into bit 7 of the shift register (LSB first); after the 8th bit -> PARITY.
REQ-018 PARITY: on fall, record odd-parity result (XOR of 8 data bits and parity bit == 1) -> STOP.
REQ-019 STOP: on fall, stop=1 and parity good -> push byte; parity bad -> parity_err pulse, no push; stop=0 with good parity -> frame_err pulse, no push; parity_err wins if both fail; always -> IDLE.
REQ-020 In any non-IDLE state, a counter SHALL clear on every fall and increment otherwise; on reaching TIMEOUT_CYCLES-1 the FSM SHALL enter IDLE and pulse frame_err.
REQ-021 Push SHALL be registered on the STOP fall cycle; code_valid SHALL be high on the following cycle (first-word fall-through).
REQ-022 Push when full and no simultaneous pop SHALL drop the new byte and pulse overflow; FIFO contents unchanged.
REQ-023 Simultaneous push and pop when full SHALL accept both; occupancy stays FIFO_DEPTH.
REQ-024 Simultaneous push and pop when empty: code_valid SHALL remain 0 that cycle; the pushed byte SHALL appear next cycle.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use log2(FIFO_DEPTH)+1 bits.

Reset
REQ-026 On reset: FSM IDLE, bit count 0, timeout counter 0, shift register 0, FIFO empty, code=0, code_valid=0, all error pulses 0.
REQ-027 On reset: synchronizer flops and filtered clock 1 (bus idle), filter sample counter 0.
REQ-028 Reset mid-frame SHALL discard the partial frame with no error pulse; the next frame SHALL be received normally.

Structure
REQ-029 Package ps2_pkg SHALL hold the frame-state enum, the default FILTER_LEN and TIMEOUT_CYCLES constants, and an odd-parity function.
REQ-030 The FIFO SHALL be a separate sub-module ps2_rx_fifo (width 8, depth FIFO_DEPTH).

Verification
REQ-031 Frame 0x1C, parity 0, stop 1, 10 kHz PS/2 clock -> code=0x1C, code_valid=1 one cycle after stop fall, no error pulses.
REQ-032 Frame 0x1C with parity 1 -> one parity_err pulse; code_valid stays 0.
REQ-033 5 bits of a frame, then silence for TIMEOUT_CYCLES -> one frame_err pulse, FSM IDLE; next frame 0x5A (parity 1) -> code=0x5A.
REQ-034 Frames 0x01..0x05 with code_ready=0 -> one overflow pulse on the 5th; popping yields 0x01,0x02,0x03,0x04, then code_valid=0.
REQ-035 3-cycle low glitch on ps2_clk_in during DATA -> no shift, bit count unchanged; frame completes with the correct byte.
REQ-036 reset asserted after the 4th data bit -> no push, no error; following frame 0xF0 (parity 1) -> code=0xF0.
